// File: rtl/uart_tx_arb.sv
// uart_tx_arb: packet-locked, round-robin arbiter sharing one UART TX byte
// interface between two packet sources, with a mid-packet stall watchdog.
`timescale 1ns/1ps

module uart_tx_arb #(
  parameter logic [15:0] STALL_LEN = 16'd1000,
  parameter logic [3:0]  BUSY_WAIT = 4'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_done,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       last0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  input  logic       last1,
  output logic       ack1,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       abort
);

  localparam int unsigned STALL_W = 16;
  localparam int unsigned WAIT_W  = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic                 prio, prio_nxt;
  logic                 last_r, last_nxt;
  logic [STALL_W-1:0]   stall_cnt, stall_nxt;
  logic [WAIT_W-1:0]    wait_cnt, wait_nxt;
  logic [1:0]           grant_nxt;
  logic                 tx_start_nxt;
  logic [7:0]           tx_data_nxt;
  logic                 ack0_nxt, ack1_nxt;
  logic                 abort_nxt;

  logic                 sel_c;
  logic                 req_g_c;
  logic [7:0]           data_g_c;
  logic                 last_g_c;

  // Mux the granted source's byte interface; grant[1] selects source 1
  always_comb begin
    sel_c    = grant[1];
    req_g_c  = sel_c ? req1  : req0;
    data_g_c = sel_c ? data1 : data0;
    last_g_c = sel_c ? last1 : last0;
  end

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      last_r    <= 1'b0;
      stall_cnt <= '0;
      wait_cnt  <= '0;
      grant     <= 2'b00;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state     <= state_nxt;
      prio      <= prio_nxt;
      last_r    <= last_nxt;
      stall_cnt <= stall_nxt;
      wait_cnt  <= wait_nxt;
      grant     <= grant_nxt;
      tx_start  <= tx_start_nxt;
      tx_data   <= tx_data_nxt;
      ack0      <= ack0_nxt;
      ack1      <= ack1_nxt;
      abort     <= abort_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    prio_nxt     = prio;
    last_nxt     = last_r;
    stall_nxt    = stall_cnt;
    wait_nxt     = wait_cnt;
    grant_nxt    = grant;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    ack0_nxt     = 1'b0;
    ack1_nxt     = 1'b0;
    abort_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (init_done && (req0 || req1)) begin
          if (req0 && req1) begin
            grant_nxt = prio ? 2'b10 : 2'b01;
          end else begin
            grant_nxt = req1 ? 2'b10 : 2'b01;
          end
          stall_nxt = '0;
          state_nxt = LOAD;
        end
      end

      LOAD: begin
        if (req_g_c) begin
          // Hold off while the UART is still shifting the previous byte
          if (!tx_busy) begin
            tx_start_nxt = 1'b1;
            tx_data_nxt  = data_g_c;
            ack0_nxt     = ~sel_c;
            ack1_nxt     = sel_c;
            last_nxt     = last_g_c;
            stall_nxt    = '0;
            wait_nxt     = '0;
            state_nxt    = WAIT_BUSY;
          end
        end else if (stall_cnt == STALL_LEN - 16'd1) begin
          abort_nxt = 1'b1;
          grant_nxt = 2'b00;
          prio_nxt  = ~sel_c;
          stall_nxt = '0;
          state_nxt = IDLE;
        end else begin
          stall_nxt = stall_cnt + 16'd1;
        end
      end

      WAIT_BUSY: begin
        // A start the UART never acknowledged times out into WAIT_DONE
        if (tx_busy || (wait_cnt == BUSY_WAIT - 4'd1)) begin
          state_nxt = WAIT_DONE;
        end else begin
          wait_nxt = wait_cnt + 4'd1;
        end
      end

      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_r) begin
            grant_nxt = 2'b00;
            prio_nxt  = ~sel_c;
            state_nxt = IDLE;
          end else begin
            stall_nxt = '0;
            state_nxt = LOAD;
          end
        end
      end

      default: begin
        grant_nxt = 2'b00;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed scenarios plus randomized traffic, checked against
// a packet/queue-level model of the two sources, the arbiter rules and a UART.
`timescale 1ns/1ps

module tb_uart_tx_arb;

  localparam logic [15:0] STALL = 16'd60;
  localparam logic [3:0]  BW    = 4'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_done;
  logic       req0, last0, ack0;
  logic [7:0] data0;
  logic       req1, last1, ack1;
  logic [7:0] data1;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [1:0] grant;
  logic       abort;

  always #5 clk = ~clk;

  uart_tx_arb #(.STALL_LEN(STALL), .BUSY_WAIT(BW)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .req0(req0), .data0(data0), .last0(last0), .ack0(ack0),
    .req1(req1), .data1(data1), .last1(last1), .ack1(ack1),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant(grant), .abort(abort)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Source model: each entry is {last, data}
  logic [8:0] src_q [2][$];

  int         cyc = 0;
  int         fall_cyc = -100;
  int         last_start_cyc = -100;
  int         abort_cyc_exp = -1;
  logic [1:0] prev_grant = 2'b00;
  logic       prio_m = 1'b0;
  logic       owner_last = 1'b0;
  logic       first_byte = 1'b0;
  logic       abort_seen = 1'b0;
  int         busy_dly = 0;
  int         busy_rem = 0;
  int         dmin = 3, dmax = 3, lmin = 20, lmax = 20;
  bit         lost = 1'b0;
  bit         rnd_on = 1'b0;
  int         n_start [2] = '{0, 0};
  int         order_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic enq_byte(input int s, input logic [7:0] d, input logic l);
    src_q[s].push_back({l, d});
  endtask

  task automatic enq_pkt(input int s, input int len);
    for (int i = 0; i < len; i++) begin
      enq_byte(s, 8'($urandom), (i == len - 1));
    end
  endtask

  task automatic drive();
    logic [8:0] h0, h1;
    h0 = (src_q[0].size() != 0) ? src_q[0][0] : 9'h000;
    h1 = (src_q[1].size() != 0) ? src_q[1][0] : 9'h000;
    req0  = (src_q[0].size() != 0);
    data0 = h0[7:0];
    last0 = h0[8];
    req1  = (src_q[1].size() != 0);
    data1 = h1[7:0];
    last1 = h1[8];
  endtask

  // One clock: capture inputs seen at the edge, check outputs, advance models
  task automatic tick();
    logic       p_req0, p_req1, p_init;
    logic [1:0] exp_g;
    logic [8:0] head;
    int         s;
    @(posedge clk);
    p_req0 = req0;
    p_req1 = req1;
    p_init = init_done;
    #1;
    cyc++;

    if (prev_grant == 2'b00) begin
      exp_g = 2'b00;
      if (p_init && (p_req0 || p_req1)) begin
        if (p_req0 && p_req1) exp_g = prio_m ? 2'b10 : 2'b01;
        else                  exp_g = p_req0 ? 2'b01 : 2'b10;
      end
      chk("grant_idle", 32'(grant), 32'(exp_g));
      if (grant != 2'b00) begin
        order_q.push_back((grant == 2'b10) ? 1 : 0);
        owner_last = 1'b0;
        first_byte = 1'b1;
      end
    end else if (grant != prev_grant) begin
      chk("grant_hop", 32'(grant), 32'd0);
      chk("release_ok", 32'(abort | owner_last), 32'd1);
      prio_m = (prev_grant == 2'b01);
    end

    if (owner_last && (fall_cyc > last_start_cyc) && (cyc == fall_cyc + 1))
      chk("release_late", 32'(grant), 32'd0);

    if (abort || (cyc == abort_cyc_exp)) begin
      chk("abort", 32'(abort), 32'(cyc == abort_cyc_exp));
      if (abort) abort_seen = 1'b1;
    end

    chk("ack", 32'({ack1, ack0}), 32'(tx_start ? grant : 2'b00));

    if (tx_start) begin
      s = (grant == 2'b10) ? 1 : 0;
      chk("start_busy", 32'(tx_busy), 32'd0);
      chk("start_turn", 32'((cyc - fall_cyc) >= 2), 32'd1);
      if (lost && !first_byte) chk("lost_gap", 32'(cyc - last_start_cyc), 32'(BW) + 32'd2);
      chk("start_nonempty", 32'(src_q[s].size() != 0), 32'd1);
      if (src_q[s].size() != 0) begin
        head = src_q[s][0];
        chk("tx_data", 32'(tx_data), 32'(head[7:0]));
        owner_last = head[8];
      end
      n_start[s]++;
      last_start_cyc = cyc;
      first_byte = 1'b0;
    end

    if (ack0 && src_q[0].size() != 0) void'(src_q[0].pop_front());
    if (ack1 && src_q[1].size() != 0) void'(src_q[1].pop_front());

    // UART model: busy rises dly cycles after a start and holds for len cycles
    if (busy_dly > 0) begin
      busy_dly--;
      if (busy_dly == 0) begin
        tx_busy  = 1'b1;
        busy_rem = $urandom_range(lmax, lmin);
      end
    end else if (tx_busy) begin
      busy_rem--;
      if (busy_rem <= 0) begin
        tx_busy  = 1'b0;
        fall_cyc = cyc;
      end
    end
    if (tx_start && !lost) busy_dly = $urandom_range(dmax, dmin);

    if (rnd_on) begin
      for (int k = 0; k < 2; k++) begin
        if (src_q[k].size() == 0 && $urandom_range(7, 0) == 0)
          enq_pkt(k, $urandom_range(4, 1));
      end
      if (init_done) begin
        if ($urandom_range(99, 0) < 2) init_done = 1'b0;
      end else if ($urandom_range(99, 0) < 30) begin
        init_done = 1'b1;
      end
    end

    drive();
    prev_grant = grant;
  endtask

  task automatic wait_idle(input int max);
    int  k;
    bit  done;
    k = 0;
    done = 1'b0;
    while (!done && k < max) begin
      tick();
      k++;
      done = (grant == 2'b00) && (src_q[0].size() == 0) && (src_q[1].size() == 0)
             && !tx_busy && (busy_dly == 0);
    end
    chk("idle_reached", 32'(done), 32'd1);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_ack", 32'({ack1, ack0}), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    src_q[0].delete();
    src_q[1].delete();
    tx_busy    = 1'b0;
    busy_dly   = 0;
    busy_rem   = 0;
    prio_m     = 1'b0;
    owner_last = 1'b0;
    fall_cyc   = -100;
    drive();
    @(posedge clk);
    #2;
    chk("rst_hold_grant", 32'(grant), 32'd0);
    rst = 1'b1;
    prev_grant = 2'b00;
  endtask

  initial begin
    int k;
    int base;
    rst       = 1'b1;
    init_done = 1'b0;
    tx_busy   = 1'b0;
    drive();
    do_reset();

    // Grants held off until init_done; then the 3-byte packet from source 0
    enq_byte(0, 8'hA5, 1'b0);
    enq_byte(0, 8'h5A, 1'b0);
    enq_byte(0, 8'hFF, 1'b1);
    repeat (50) tick();
    chk("gated_starts", 32'(n_start[0] + n_start[1]), 32'd0);
    init_done = 1'b1;
    tick();
    chk("grant_after_init", 32'(grant), 32'd1);
    wait_idle(1000);
    chk("pkt3_starts", 32'(n_start[0]), 32'd3);

    // UART never raises busy: each byte times out and the packet continues
    lost = 1'b1;
    enq_byte(0, 8'h11, 1'b0);
    enq_byte(0, 8'h22, 1'b0);
    enq_byte(0, 8'h33, 1'b1);
    wait_idle(500);
    chk("lost_starts", 32'(n_start[0]), 32'd6);
    lost = 1'b0;

    // Reset while source 1 is mid-byte
    dmin = 1; dmax = 4; lmin = 2; lmax = 8;
    enq_byte(1, 8'h81, 1'b0);
    enq_byte(1, 8'h82, 1'b0);
    enq_byte(1, 8'h83, 1'b0);
    enq_byte(1, 8'h84, 1'b1);
    k = 0;
    while (!tx_busy && k < 100) begin
      tick();
      k++;
    end
    chk("busy_seen", 32'(tx_busy), 32'd1);
    do_reset();
    repeat (5) tick();

    // Both sources with two 2-byte packets each: strict alternation from source 0
    order_q.delete();
    enq_pkt(0, 2); enq_pkt(0, 2);
    enq_pkt(1, 2); enq_pkt(1, 2);
    wait_idle(2000);
    chk("order_n", 32'(order_q.size()), 32'd4);
    if (order_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("order", 32'(order_q[i]), 32'(i % 2));
    end

    // Source 1 stalls after one non-last byte; watchdog revokes, source 0 follows
    base = n_start[1];
    enq_byte(1, 8'h3C, 1'b0);
    k = 0;
    while ((n_start[1] == base || fall_cyc <= last_start_cyc) && k < 200) begin
      tick();
      k++;
    end
    chk("stall_byte_done", 32'(k < 200), 32'd1);
    abort_cyc_exp = fall_cyc + 1 + int'(STALL);
    enq_byte(0, 8'hC3, 1'b1);
    abort_seen = 1'b0;
    k = 0;
    while (!abort_seen && k < int'(STALL) + 50) begin
      tick();
      k++;
    end
    chk("abort_seen", 32'(abort_seen), 32'd1);
    abort_cyc_exp = -1;
    tick();
    chk("grant_after_abort", 32'(grant), 32'd1);
    wait_idle(500);

    // Randomized traffic, UART timing and init_done toggling
    rnd_on = 1'b1;
    repeat (3000) tick();
    rnd_on = 1'b0;
    init_done = 1'b1;
    wait_idle(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
